// File: rtl/fht_bfly_sched.sv
// Address/strobe sequencer that time-shares one butterfly across an N-point radix-2 FHT pass.
// Issues one DIF butterfly per cycle and a write-back one cycle later into a ping-pong buffer.
module fht_bfly_sched #(
    parameter int unsigned LOG2N = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             rd_bank,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic             bfly_vld,
    output logic             wr_en,
    output logic             wr_bank,
    output logic [LOG2N-1:0] wr_addr_c,
    output logic [LOG2N-1:0] wr_addr_d,
    output logic [LOG2N-1:0] stage
);

    localparam int unsigned N    = 1 << LOG2N;
    localparam int unsigned HALF = N / 2;
    localparam int unsigned KW   = LOG2N - 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [LOG2N-1:0] stage_q, stage_d;
    logic             vld_q, vld_d;
    logic [LOG2N-1:0] addr_a_q, addr_a_d;
    logic [LOG2N-1:0] addr_b_q, addr_b_d;
    logic             wr_en_q;
    logic             wr_bank_q;
    logic [LOG2N-1:0] wr_addr_c_q, wr_addr_d_q;

    // Distance between the two operands of a butterfly in stage s.
    function automatic logic [LOG2N-1:0] span_of(input logic [LOG2N-1:0] s);
        int unsigned sl;
        sl = LOG2N - 1 - 32'(s);
        return LOG2N'(1) << sl;
    endfunction

    // Insert a zero at bit position log2(span) of k to get operand a.
    function automatic logic [LOG2N-1:0] addr_a_of(input logic [KW-1:0] k,
                                                   input logic [LOG2N-1:0] s);
        int unsigned      sl;
        logic [LOG2N-1:0] kx;
        logic [LOG2N-1:0] lo_mask;
        sl      = LOG2N - 1 - 32'(s);
        kx      = LOG2N'(k);
        lo_mask = span_of(s) - LOG2N'(1);
        return ((kx >> sl) << (sl + 1)) | (kx & lo_mask);
    endfunction

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        stage_d  = stage_q;
        vld_d    = 1'b0;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StIssue;
                    k_d     = '0;
                    stage_d = '0;
                    vld_d   = 1'b1;
                end
            end
            StIssue: begin
                if (k_q == KW'(HALF - 1)) begin
                    if (stage_q == LOG2N'(LOG2N - 1)) begin
                        state_d = StDrain;
                    end else begin
                        // Stage boundary: no bubble, the buffer bypasses the last write.
                        k_d     = '0;
                        stage_d = stage_q + LOG2N'(1);
                        vld_d   = 1'b1;
                    end
                end else begin
                    k_d   = k_q + KW'(1);
                    vld_d = 1'b1;
                end
            end
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (vld_d) begin
            addr_a_d = addr_a_of(k_d, stage_d);
            addr_b_d = addr_a_d | span_of(stage_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            k_q         <= '0;
            stage_q     <= '0;
            vld_q       <= 1'b0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            wr_en_q     <= 1'b0;
            wr_bank_q   <= 1'b0;
            wr_addr_c_q <= '0;
            wr_addr_d_q <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            stage_q  <= stage_d;
            vld_q    <= vld_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            wr_en_q  <= vld_q;
            // Write addresses hold their last value when no butterfly is in flight.
            if (vld_q) begin
                wr_bank_q   <= ~stage_q[0];
                wr_addr_c_q <= addr_a_q;
                wr_addr_d_q <= addr_b_q;
            end
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign rd_bank   = stage_q[0];
    assign rd_addr_a = addr_a_q;
    assign rd_addr_b = addr_b_q;
    assign bfly_vld  = vld_q;
    assign wr_en     = wr_en_q;
    assign wr_bank   = wr_bank_q;
    assign wr_addr_c = wr_addr_c_q;
    assign wr_addr_d = wr_addr_d_q;
    assign stage     = stage_q;

endmodule
